// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared encodings and defaults for the snake direction controller
package snake_pkg;

  // Default debounce window in clk cycles
  localparam int DB_CYCLES_DEF = 250000;

  // Direction encodings; opposite directions differ only in bit 1
  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  // Game control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Direction that would reverse the snake onto itself
  function automatic logic [1:0] dir_opposite(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_btn_debounce.sv
// rtl/snake_btn_debounce.sv - 2-flop synchronizer, stability counter and press pulse for one button
module snake_btn_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  // Counter only needs to reach DB_CYCLES-1
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Accept a new level after DB_CYCLES consecutive differing samples; pulse on accepted rise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        press <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - button-driven direction/run control for the snake game; SNAKE_DIR_QUEUE_EN selects a 2-deep turn queue
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int         DB_CYCLES = DB_CYCLES_DEF,
  parameter logic [1:0] INIT_DIR  = DIR_RIGHT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       l,
  input  logic       r,
  input  logic       u,
  input  logic       d,
  input  logic       h,
  input  logic       tick,
  output logic [1:0] dir,
  output logic       dir_chg,
  output logic       running,
  output logic       paused
);

`ifdef SNAKE_DIR_QUEUE_EN
  localparam int QDEPTH = 2;
`else
  localparam int QDEPTH = 1;
`endif

  logic p_start, p_h, p_u, p_r, p_d, p_l;

  snake_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (.clk(clk), .rst(rst), .raw(start), .press(p_start));
  snake_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_h     (.clk(clk), .rst(rst), .raw(h),     .press(p_h));
  snake_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_u     (.clk(clk), .rst(rst), .raw(u),     .press(p_u));
  snake_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_r     (.clk(clk), .rst(rst), .raw(r),     .press(p_r));
  snake_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_d     (.clk(clk), .rst(rst), .raw(d),     .press(p_d));
  snake_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_l     (.clk(clk), .rst(rst), .raw(l),     .press(p_l));

  state_t     state;
  state_t     state_nxt;

  logic [1:0] q     [QDEPTH];
  logic [1:0] q_nxt [QDEPTH];
  logic [1:0] cnt;
  logic [1:0] cnt_nxt;
  logic [1:0] dir_nxt;
  logic       chg_nxt;
  logic [1:0] ref_dir;
  logic       pv;
  logic [1:0] pdir;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next state: start always (re)starts a game and beats a simultaneous hold
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (p_start) state_nxt = ST_RUN;
      ST_RUN:   if (p_start) state_nxt = ST_RUN;
                else if (p_h) state_nxt = ST_PAUSE;
      ST_PAUSE: if (p_start || p_h) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state
  always_comb begin
    running = (state == ST_RUN);
    paused  = (state == ST_PAUSE);
  end

  // Collapse simultaneous direction presses to one, priority u > r > d > l
  always_comb begin
    pv   = p_u | p_r | p_d | p_l;
    pdir = p_u ? DIR_UP : p_r ? DIR_RIGHT : p_d ? DIR_DOWN : DIR_LEFT;
  end

  // Turn queue: pop on tick first, then judge the press against the post-pop tail (or dir)
  always_comb begin
    q_nxt   = q;
    cnt_nxt = cnt;
    dir_nxt = dir;
    chg_nxt = 1'b0;
    ref_dir = dir;
    if (p_start) begin
      cnt_nxt = 2'd0;
      dir_nxt = INIT_DIR;
      chg_nxt = (dir != INIT_DIR);
      for (int i = 0; i < QDEPTH; i++) q_nxt[i] = 2'd0;
    end else if (state == ST_RUN) begin
      if (tick && cnt != 2'd0) begin
        dir_nxt = q[0];
        chg_nxt = 1'b1;
        for (int i = 0; i < QDEPTH - 1; i++) q_nxt[i] = q[i+1];
        cnt_nxt = cnt - 2'd1;
      end
      ref_dir = dir_nxt;
      for (int i = 0; i < QDEPTH; i++) begin
        if (int'(cnt_nxt) == i + 1) ref_dir = q_nxt[i];
      end
      if (pv && pdir != ref_dir && pdir != dir_opposite(ref_dir) && int'(cnt_nxt) < QDEPTH) begin
        for (int i = 0; i < QDEPTH; i++) begin
          if (int'(cnt_nxt) == i) q_nxt[i] = pdir;
        end
        cnt_nxt = cnt_nxt + 2'd1;
      end
    end
  end

  // Direction, change pulse and queue storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dir     <= INIT_DIR;
      dir_chg <= 1'b0;
      cnt     <= 2'd0;
      for (int i = 0; i < QDEPTH; i++) q[i] <= 2'd0;
    end else begin
      dir     <= dir_nxt;
      dir_chg <= chg_nxt;
      cnt     <= cnt_nxt;
      for (int i = 0; i < QDEPTH; i++) q[i] <= q_nxt[i];
    end
  end

endmodule
